// File: rtl/superscalar_ctrl_stage.sv
// Decode-stage control for a WAYS-wide MIPS bundle: decode, branch resolve, squash, ID/EX, mult FSM.
// Optional macro LINK_EN adds jal/jr decoding with linke/jre outputs.
module superscalar_ctrl_stage #(
  parameter int unsigned WAYS     = 2,
  parameter int unsigned MULT_LAT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [32*WAYS-1:0]    instrd,
  input  logic [WAYS-1:0]       validd,
  input  logic [WAYS-1:0]       equald,
  input  logic                  stalld,
  input  logic                  flushe,
  output logic [1:0]            pcsrcd,
  output logic [$clog2(WAYS):0] takenslotd,
  output logic                  multstalld,
  output logic [WAYS-1:0]       vale,
  output logic [WAYS-1:0]       regwritee,
  output logic [WAYS-1:0]       memtorege,
  output logic [WAYS-1:0]       memwritee,
  output logic [WAYS-1:0]       alusrce,
  output logic [WAYS-1:0]       regdste,
  output logic [WAYS-1:0]       multsele,
  output logic [WAYS-1:0]       signe,
  output logic [3*WAYS-1:0]     alucontrole
`ifdef LINK_EN
  ,
  output logic [WAYS-1:0]       linke,
  output logic [WAYS-1:0]       jre
`endif
);

  localparam int unsigned TW = $clog2(WAYS) + 1;
  localparam int unsigned CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic {StIdle, StBusy} state_e;

  logic [WAYS-1:0]   w_regwrite, w_memtoreg, w_memwrite, w_alusrc, w_regdst, w_multsel, w_sign;
  logic [WAYS-1:0]   w_beq, w_bne, w_jump;
  logic [3*WAYS-1:0] w_alu;
  logic [WAYS-1:0]   w_taken, w_live, w_issue;
  logic [3*WAYS-1:0] w_issue3;
  logic              w_mult_req;
`ifdef LINK_EN
  logic [WAYS-1:0]   w_link, w_jr;
  logic [WAYS-1:0]   r_link;
`endif

  state_e            r_state, w_state_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;

  logic [WAYS-1:0]   r_val, r_regwrite, r_memtoreg, r_memwrite, r_alusrc, r_regdst, r_multsel;
  logic [WAYS-1:0]   r_sign;
  logic [3*WAYS-1:0] r_alu;

  always_comb begin : decode
    logic [5:0] op;
    logic [5:0] fn;
    w_regwrite = '0;
    w_memtoreg = '0;
    w_memwrite = '0;
    w_alusrc   = '0;
    w_regdst   = '0;
    w_multsel  = '0;
    w_sign     = '0;
    w_beq      = '0;
    w_bne      = '0;
    w_jump     = '0;
    w_alu      = '0;
`ifdef LINK_EN
    w_link     = '0;
    w_jr       = '0;
`endif
    for (int k = 0; k < WAYS; k++) begin
      op = instrd[32*k+26 +: 6];
      fn = instrd[32*k +: 6];
      case (op)
        6'b000000: begin
          w_regwrite[k] = 1'b1;
          w_regdst[k]   = 1'b1;
          w_sign[k]     = 1'b1;
          case (fn)
            6'b100000: w_alu[3*k +: 3] = 3'b010;
            6'b100001: begin
              w_alu[3*k +: 3] = 3'b010;
              w_sign[k]       = 1'b0;
            end
            6'b100010: w_alu[3*k +: 3] = 3'b110;
            6'b100011: begin
              w_alu[3*k +: 3] = 3'b110;
              w_sign[k]       = 1'b0;
            end
            6'b100100: w_alu[3*k +: 3] = 3'b000;
            6'b100101: w_alu[3*k +: 3] = 3'b001;
            6'b101010: w_alu[3*k +: 3] = 3'b111;
            6'b011000: begin
              w_alu[3*k +: 3] = 3'b010;
              w_multsel[k]    = 1'b1;
            end
`ifdef LINK_EN
            6'b001000: begin
              w_regwrite[k] = 1'b0;
              w_regdst[k]   = 1'b0;
              w_jump[k]     = 1'b1;
              w_jr[k]       = 1'b1;
            end
`endif
            // Unknown funct is a NOP: nothing may write.
            default: begin
              w_regwrite[k] = 1'b0;
              w_regdst[k]   = 1'b0;
              w_sign[k]     = 1'b0;
            end
          endcase
        end
        6'b100011: begin
          w_regwrite[k]   = 1'b1;
          w_memtoreg[k]   = 1'b1;
          w_alusrc[k]     = 1'b1;
          w_sign[k]       = 1'b1;
          w_alu[3*k +: 3] = 3'b010;
        end
        6'b101011: begin
          w_memwrite[k]   = 1'b1;
          w_alusrc[k]     = 1'b1;
          w_sign[k]       = 1'b1;
          w_alu[3*k +: 3] = 3'b010;
        end
        6'b000100: begin
          w_beq[k]        = 1'b1;
          w_sign[k]       = 1'b1;
          w_alu[3*k +: 3] = 3'b110;
        end
        6'b000101: begin
          w_bne[k]        = 1'b1;
          w_sign[k]       = 1'b1;
          w_alu[3*k +: 3] = 3'b110;
        end
        6'b001000, 6'b001001: begin
          w_regwrite[k]   = 1'b1;
          w_alusrc[k]     = 1'b1;
          w_sign[k]       = (op == 6'b001000);
          w_alu[3*k +: 3] = 3'b010;
        end
        6'b000010: begin
          w_jump[k] = 1'b1;
          w_sign[k] = 1'b1;
        end
`ifdef LINK_EN
        6'b000011: begin
          w_jump[k]     = 1'b1;
          w_link[k]     = 1'b1;
          w_regwrite[k] = 1'b1;
          w_sign[k]     = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Oldest taken slot wins; everything younger than it is squashed.
  always_comb begin : resolve
    logic found;
    found      = 1'b0;
    pcsrcd     = 2'b00;
    takenslotd = TW'(WAYS);
    w_taken    = '0;
    w_live     = '0;
    for (int k = 0; k < WAYS; k++) begin
      w_taken[k] = validd[k] & ((w_beq[k] & equald[k]) | (w_bne[k] & ~equald[k]) | w_jump[k]);
      w_live[k]  = ~found;
      if (!found && w_taken[k]) begin
        found      = 1'b1;
        pcsrcd     = w_jump[k] ? 2'b10 : 2'b01;
        takenslotd = TW'(k);
      end
    end
  end

  always_comb begin
    w_issue  = validd & w_live;
    w_issue3 = '0;
    for (int k = 0; k < WAYS; k++) begin
      w_issue3[3*k +: 3] = {3{w_issue[k]}};
    end
    w_mult_req = |(w_issue & w_multsel);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_mult_req && !stalld && !flushe) begin
          w_state_next = StBusy;
          w_cnt_next   = CW'(MULT_LAT - 1);
        end
      end
      StBusy: begin
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end
      end
    endcase
  end

  always_comb begin
    multstalld = (r_state == StBusy) && w_mult_req;
  end

  // Squashed or invalid slots load all-zero controls so no write can escape.
  always_ff @(posedge clk) begin
    if (reset || flushe) begin
      r_val      <= '0;
      r_regwrite <= '0;
      r_memtoreg <= '0;
      r_memwrite <= '0;
      r_alusrc   <= '0;
      r_regdst   <= '0;
      r_multsel  <= '0;
      r_sign     <= '0;
      r_alu      <= '0;
`ifdef LINK_EN
      r_link     <= '0;
`endif
    end else if (!(stalld || multstalld)) begin
      r_val      <= w_issue;
      r_regwrite <= w_regwrite & w_issue;
      r_memtoreg <= w_memtoreg & w_issue;
      r_memwrite <= w_memwrite & w_issue;
      r_alusrc   <= w_alusrc & w_issue;
      r_regdst   <= w_regdst & w_issue;
      r_multsel  <= w_multsel & w_issue;
      r_sign     <= w_sign & w_issue;
      r_alu      <= w_alu & w_issue3;
`ifdef LINK_EN
      r_link     <= w_link & w_issue;
`endif
    end
  end

  assign vale        = r_val;
  assign regwritee   = r_regwrite;
  assign memtorege   = r_memtoreg;
  assign memwritee   = r_memwrite;
  assign alusrce     = r_alusrc;
  assign regdste     = r_regdst;
  assign multsele    = r_multsel;
  assign signe       = r_sign;
  assign alucontrole = r_alu;
`ifdef LINK_EN
  assign linke       = r_link;
  assign jre         = w_jr & w_issue;
`endif

endmodule

// File: tb/tb_superscalar_ctrl_stage.sv
// Randomized bench for superscalar_ctrl_stage against a cycle-level reference model.
module tb_superscalar_ctrl_stage;

  localparam int WAYS     = 2;
  localparam int MULT_LAT = 4;
  localparam int TW       = $clog2(WAYS) + 1;

  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_ADD  = 32'h0000_0020;
  localparam logic [31:0] I_MULT = 32'h0000_0018;
  localparam logic [31:0] I_LW   = {6'b100011, 26'd0};
  localparam logic [31:0] I_BEQ  = {6'b000100, 26'd0};
  localparam logic [31:0] I_BNE  = {6'b000101, 26'd0};

  typedef struct packed {
    logic       rw, mtr, mw, as, rd, ms, sg;
    logic [2:0] alu;
    logic       beq, bne, jmp;
  } ctl_t;

  logic                 clk;
  logic                 reset;
  logic [32*WAYS-1:0]   instrd;
  logic [WAYS-1:0]      validd, equald;
  logic                 stalld, flushe;
  logic [1:0]           pcsrcd;
  logic [TW-1:0]        takenslotd;
  logic                 multstalld;
  logic [WAYS-1:0]      vale, regwritee, memtorege, memwritee, alusrce, regdste, multsele, signe;
  logic [3*WAYS-1:0]    alucontrole;

  superscalar_ctrl_stage #(
    .WAYS     (WAYS),
    .MULT_LAT (MULT_LAT)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .instrd      (instrd),
    .validd      (validd),
    .equald      (equald),
    .stalld      (stalld),
    .flushe      (flushe),
    .pcsrcd      (pcsrcd),
    .takenslotd  (takenslotd),
    .multstalld  (multstalld),
    .vale        (vale),
    .regwritee   (regwritee),
    .memtorege   (memtorege),
    .memwritee   (memwritee),
    .alusrce     (alusrce),
    .regdste     (regdste),
    .multsele    (multsele),
    .signe       (signe),
    .alucontrole (alucontrole)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: expected ID/EX contents and the cycle at which the multiplier frees up.
  logic [WAYS-1:0]   exp_val, exp_rw, exp_mtr, exp_mw, exp_as, exp_rd, exp_ms, exp_sg;
  logic [3*WAYS-1:0] exp_alu;
  int                cyc        = 0;
  int                busy_until = 0;
  bit                known      = 1'b0;

  logic [1:0]        obs_pc;
  logic [TW-1:0]     obs_tk;
  logic              obs_ms;
  logic [63:0]       rnd_ins;
  ctl_t              c0, c1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic ctl_t decode(input logic [31:0] ins);
    ctl_t c;
    bit   r_ok;
    c    = '0;
    r_ok = 1'b1;
    case (ins[31:26])
      6'b000000: begin
        case (ins[5:0])
          6'b100000: begin c.alu = 3'b010; c.sg = 1'b1; end
          6'b100001: c.alu = 3'b010;
          6'b100010: begin c.alu = 3'b110; c.sg = 1'b1; end
          6'b100011: c.alu = 3'b110;
          6'b100100: begin c.alu = 3'b000; c.sg = 1'b1; end
          6'b100101: begin c.alu = 3'b001; c.sg = 1'b1; end
          6'b101010: begin c.alu = 3'b111; c.sg = 1'b1; end
          6'b011000: begin c.alu = 3'b010; c.sg = 1'b1; c.ms = 1'b1; end
          default:   r_ok = 1'b0;
        endcase
        c.rw = r_ok;
        c.rd = r_ok;
      end
      6'b100011: begin c.rw = 1; c.mtr = 1; c.as = 1; c.sg = 1; c.alu = 3'b010; end
      6'b101011: begin c.mw = 1; c.as = 1; c.sg = 1; c.alu = 3'b010; end
      6'b000100: begin c.beq = 1; c.sg = 1; c.alu = 3'b110; end
      6'b000101: begin c.bne = 1; c.sg = 1; c.alu = 3'b110; end
      6'b001000: begin c.rw = 1; c.as = 1; c.sg = 1; c.alu = 3'b010; end
      6'b001001: begin c.rw = 1; c.as = 1; c.alu = 3'b010; end
      6'b000010: begin c.jmp = 1; c.sg = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] pick_funct();
    logic [5:0] f;
    case ($urandom_range(0, 8))
      0: f = 6'b100000;
      1: f = 6'b100001;
      2: f = 6'b100010;
      3: f = 6'b100011;
      4: f = 6'b100100;
      5: f = 6'b100101;
      6: f = 6'b101010;
      7: f = 6'b011000;
      default: f = 6'($urandom());
    endcase
    return f;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 13))
      0, 1, 2:   begin r[31:26] = 6'b000000; r[5:0] = pick_funct(); end
      3:         r[31:26] = 6'b100011;
      4:         r[31:26] = 6'b101011;
      5:         r[31:26] = 6'b000100;
      6:         r[31:26] = 6'b000101;
      7:         r[31:26] = 6'b001000;
      8:         r[31:26] = 6'b001001;
      9:         r[31:26] = 6'b000010;
      10, 11, 12: begin r[31:26] = 6'b000000; r[5:0] = 6'b011000; end
      default: ;
    endcase
    return r;
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model, check ID/EX.
  task automatic step(input logic [63:0] ins, input logic [1:0] v, input logic [1:0] eq,
                      input logic st, input logic fl, input logic rs);
    ctl_t            c [WAYS];
    logic [WAYS-1:0] iss;
    bit              found, busy, mreq, mstall;
    logic [1:0]      pc;
    int              tk;
    @(negedge clk);
    instrd = ins;
    validd = v;
    equald = eq;
    stalld = st;
    flushe = fl;
    reset  = rs;
    #1;
    found = 1'b0;
    pc    = 2'b00;
    tk    = WAYS;
    iss   = '0;
    mreq  = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      c[k] = decode(ins[32*k +: 32]);
      if (!found && v[k]) iss[k] = 1'b1;
      if (iss[k] && c[k].ms) mreq = 1'b1;
      if (!found && v[k] && (c[k].jmp || (c[k].beq && eq[k]) || (c[k].bne && !eq[k]))) begin
        found = 1'b1;
        pc    = c[k].jmp ? 2'b10 : 2'b01;
        tk    = k;
      end
    end
    busy   = cyc < busy_until;
    mstall = busy && mreq;
    obs_pc = pcsrcd;
    obs_tk = takenslotd;
    obs_ms = multstalld;
    check_eq("pcsrcd", 32'(pcsrcd), 32'(pc));
    check_eq("takenslotd", 32'(takenslotd), 32'(tk));
    if (known) check_eq("multstalld", 32'(multstalld), 32'(mstall));

    if (rs || fl) begin
      exp_val = '0; exp_rw = '0; exp_mtr = '0; exp_mw = '0; exp_as = '0;
      exp_rd  = '0; exp_ms = '0; exp_sg  = '0; exp_alu = '0;
    end else if (!(st || mstall)) begin
      for (int k = 0; k < WAYS; k++) begin
        exp_val[k]         = iss[k];
        exp_rw[k]          = iss[k] & c[k].rw;
        exp_mtr[k]         = iss[k] & c[k].mtr;
        exp_mw[k]          = iss[k] & c[k].mw;
        exp_as[k]          = iss[k] & c[k].as;
        exp_rd[k]          = iss[k] & c[k].rd;
        exp_ms[k]          = iss[k] & c[k].ms;
        exp_sg[k]          = iss[k] & c[k].sg;
        exp_alu[3*k +: 3]  = iss[k] ? c[k].alu : 3'b000;
      end
    end
    if (rs) busy_until = 0;
    else if (!busy && mreq && !st && !fl) busy_until = cyc + MULT_LAT;
    if (rs) known = 1'b1;

    @(posedge clk);
    #1;
    cyc++;
    if (known) begin
      check_eq("vale", 32'(vale), 32'(exp_val));
      check_eq("regwritee", 32'(regwritee), 32'(exp_rw));
      check_eq("memtorege", 32'(memtorege), 32'(exp_mtr));
      check_eq("memwritee", 32'(memwritee), 32'(exp_mw));
      check_eq("alusrce", 32'(alusrce), 32'(exp_as));
      check_eq("regdste", 32'(regdste), 32'(exp_rd));
      check_eq("multsele", 32'(multsele), 32'(exp_ms));
      check_eq("signe", 32'(signe), 32'(exp_sg));
      check_eq("alucontrole", 32'(alucontrole), 32'(exp_alu));
    end
  endtask

  initial begin
    reset  = 1'b1;
    instrd = '0;
    validd = '0;
    equald = '0;
    stalld = 1'b0;
    flushe = 1'b0;

    // Reset, then a lw in slot 0.
    step({I_NOP, I_LW}, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    check_eq("rst_vale", 32'(vale), 32'd0);
    check_eq("rst_regwritee", 32'(regwritee), 32'd0);
    step({I_NOP, I_LW}, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check_eq("lw_regwrite", 32'(regwritee[0]), 32'd1);
    check_eq("lw_memtoreg", 32'(memtorege[0]), 32'd1);
    check_eq("lw_alu", 32'(alucontrole[2:0]), 32'd2);

    // Taken beq in slot 0 squashes slot 1.
    step({I_ADD, I_BEQ}, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
    check_eq("beq_pcsrc", 32'(obs_pc), 32'd1);
    check_eq("beq_slot", 32'(obs_tk), 32'd0);
    check_eq("beq_vale", 32'(vale), 32'd1);

    // bne in slot 1: taken, then not taken.
    step({I_BNE, I_ADD}, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    check_eq("bne_pcsrc", 32'(obs_pc), 32'd1);
    check_eq("bne_slot", 32'(obs_tk), 32'd1);
    check_eq("bne_vale", 32'(vale), 32'd3);
    step({I_BNE, I_ADD}, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
    check_eq("bnent_pcsrc", 32'(obs_pc), 32'd0);
    check_eq("bnent_slot", 32'(obs_tk), 32'd2);

    // Back-to-back mults: three stall cycles, the fourth issues.
    step({I_NOP, I_MULT}, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check_eq("mult0_stall", 32'(obs_ms), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step({I_NOP, I_MULT}, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
      check_eq("mult_stall_seq", 32'(obs_ms), (i < 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) step({I_NOP, I_NOP}, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Flush beats stall.
    step({I_NOP, I_ADD}, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    step({I_NOP, I_ADD}, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    check_eq("flush_vale", 32'(vale), 32'd0);
    check_eq("flush_regwrite", 32'(regwritee), 32'd0);

    // Reset while the multiplier is busy with two cycles left.
    step({I_NOP, I_MULT}, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    step({I_NOP, I_MULT}, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    step({I_NOP, I_MULT}, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    check_eq("rstbusy_stall", 32'(obs_ms), 32'd1);
    step({I_NOP, I_MULT}, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check_eq("postrst_stall", 32'(obs_ms), 32'd0);
    check_eq("postrst_multsel", 32'(multsele[0]), 32'd1);
    for (int i = 0; i < 4; i++) step({I_NOP, I_NOP}, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Random traffic; at most one mult per bundle.
    for (int n = 0; n < 400; n++) begin
      rnd_ins[31:0]  = rand_instr();
      rnd_ins[63:32] = rand_instr();
      c0 = decode(rnd_ins[31:0]);
      c1 = decode(rnd_ins[63:32]);
      if (c0.ms && c1.ms) rnd_ins[63:32] = I_ADD;
      step(rnd_ins, 2'($urandom()), 2'($urandom()), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
